next_pc_logic: RTL and testbench

NEXT_PC_LOGIC -- requirements
Module: NextPClogic

---
 rtl/next_pc_logic_pkg.sv | 6 +
 rtl/nextpc_sat_counter.sv | 18 +
 rtl/next_pc_logic.sv | 51 +++++
 tb/tb_next_pc_logic.sv | 136 +++++++++++++
 4 files changed

// File: rtl/next_pc_logic_pkg.sv
// next_pc_logic_pkg: shared widths and parameter defaults for the next-PC block
package next_pc_logic_pkg;
  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned DEF_PC_INCR = 4;
  localparam int unsigned DEF_CNT_W   = 32;
endpackage

// File: rtl/nextpc_sat_counter.sv
// nextpc_sat_counter: enabled up-counter with synchronous reset that sticks at all-ones
module nextpc_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  logic [W-1:0] r_cnt;
  logic         w_full;
  assign w_full = &r_cnt;
  // count enabled events; reset wins over a pending increment, hold once saturated
  always_ff @(posedge i_clk)
    r_cnt <= i_rst ? '0 : (i_en && !w_full) ? r_cnt + ONE : r_cnt;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/next_pc_logic.sv
// next_pc_logic: combinational next-PC select with registered taken flag; NEXTPC_STATS_EN adds saturating branch counters
module next_pc_logic
  import next_pc_logic_pkg::*;
#(
  parameter int unsigned PC_INCR = DEF_PC_INCR,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] CurrentPC,
  input  logic [ADDR_W-1:0] SignExtImm64,
  input  logic              Branch,
  input  logic              ALUZero,
  input  logic              Uncondbranch,
  output logic [ADDR_W-1:0] NextPC,
  output logic              Taken,
`ifdef NEXTPC_STATS_EN
  output logic [CNT_W-1:0]  TakenCnt,
  output logic [CNT_W-1:0]  CondCnt,
  output logic [CNT_W-1:0]  UncondCnt,
`endif
  output logic              TakenQ
);
  logic [ADDR_W-1:0] w_seq_pc;
  logic [ADDR_W-1:0] w_br_pc;
  logic              w_taken;
  logic              r_taken_q;
  // both targets computed every cycle; additions wrap modulo 2^64 by construction
  always_comb begin
    w_taken  = Uncondbranch | (Branch & ALUZero);
    w_seq_pc = CurrentPC + ADDR_W'(PC_INCR);
    w_br_pc  = CurrentPC + SignExtImm64;
  end
  assign Taken  = w_taken;
  assign NextPC = w_taken ? w_br_pc : w_seq_pc;
  // capture the taken decision each cycle; cleared by reset
  always_ff @(posedge CLK)
    r_taken_q <= Reset ? 1'b0 : w_taken;
  assign TakenQ = r_taken_q;
`ifdef NEXTPC_STATS_EN
  nextpc_sat_counter #(.W(CNT_W)) u_taken_cnt (
    .i_clk(CLK), .i_rst(Reset), .i_en(w_taken), .o_cnt(TakenCnt)
  );
  nextpc_sat_counter #(.W(CNT_W)) u_cond_cnt (
    .i_clk(CLK), .i_rst(Reset), .i_en(Branch), .o_cnt(CondCnt)
  );
  nextpc_sat_counter #(.W(CNT_W)) u_uncond_cnt (
    .i_clk(CLK), .i_rst(Reset), .i_en(Uncondbranch), .o_cnt(UncondCnt)
  );
`endif
endmodule

// File: tb/tb_next_pc_logic.sv
// tb_next_pc_logic: directed self-checking bench for next_pc_logic (counter checks when NEXTPC_STATS_EN is defined)
module tb_next_pc_logic;
  logic        CLK;
  logic        Reset;
  logic [63:0] CurrentPC;
  logic [63:0] SignExtImm64;
  logic        Branch;
  logic        ALUZero;
  logic        Uncondbranch;
  logic [63:0] NextPC;
  logic        Taken;
  logic        TakenQ;
`ifdef NEXTPC_STATS_EN
  logic [1:0]  TakenCnt;
  logic [1:0]  CondCnt;
  logic [1:0]  UncondCnt;
`endif
  int checks = 0;
  int errors = 0;

  next_pc_logic #(.PC_INCR(4), .CNT_W(2)) dut (
    .CLK(CLK),
    .Reset(Reset),
    .CurrentPC(CurrentPC),
    .SignExtImm64(SignExtImm64),
    .Branch(Branch),
    .ALUZero(ALUZero),
    .Uncondbranch(Uncondbranch),
    .NextPC(NextPC),
    .Taken(Taken),
`ifdef NEXTPC_STATS_EN
    .TakenCnt(TakenCnt),
    .CondCnt(CondCnt),
    .UncondCnt(UncondCnt),
`endif
    .TakenQ(TakenQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] pc, input logic [63:0] imm,
                       input logic b, input logic z, input logic u);
    CurrentPC    = pc;
    SignExtImm64 = imm;
    Branch       = b;
    ALUZero      = z;
    Uncondbranch = u;
    #1;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    drive(64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    chk("reset_takenq", {63'd0, TakenQ}, 64'd0);
`ifdef NEXTPC_STATS_EN
    chk("reset_takencnt", {62'd0, TakenCnt}, 64'd0);
    chk("reset_condcnt", {62'd0, CondCnt}, 64'd0);
    chk("reset_uncondcnt", {62'd0, UncondCnt}, 64'd0);
`endif
    chk("reset_ignored_taken", {63'd0, Taken}, 64'd1);
    chk("reset_ignored_nextpc", NextPC, 64'h0);
    Reset = 1'b0;
    drive(64'h2A, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("seq_nextpc", NextPC, 64'h2E);
    chk("seq_taken", {63'd0, Taken}, 64'd0);
    drive(64'hF1, 64'h1, 1'b0, 1'b0, 1'b0);
    chk("imm_ignored", NextPC, 64'hF5);
    drive(64'h23AA, 64'h2, 1'b1, 1'b1, 1'b0);
    chk("cond_taken_nextpc", NextPC, 64'h23AC);
    chk("cond_taken_taken", {63'd0, Taken}, 64'd1);
    tick();
    chk("cond_taken_takenq", {63'd0, TakenQ}, 64'd1);
    drive(64'h9728, 64'h3, 1'b1, 1'b0, 1'b0);
    chk("cond_not_taken_nextpc", NextPC, 64'h972C);
    chk("cond_not_taken_taken", {63'd0, Taken}, 64'd0);
    tick();
    chk("cond_not_taken_takenq", {63'd0, TakenQ}, 64'd0);
    drive(64'h2E, 64'h4, 1'b0, 1'b0, 1'b1);
    chk("uncond_nextpc", NextPC, 64'h32);
    chk("uncond_taken", {63'd0, Taken}, 64'd1);
    drive(64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 1'b1);
    chk("backward_nextpc", NextPC, 64'hF8);
    drive(64'h500, 64'h40, 1'b1, 1'b0, 1'b1);
    chk("both_zero0_taken", {63'd0, Taken}, 64'd1);
    chk("both_zero0_nextpc", NextPC, 64'h540);
    drive(64'h500, 64'h40, 1'b0, 1'b1, 1'b0);
    chk("aluzero_ignored_taken", {63'd0, Taken}, 64'd0);
    chk("aluzero_ignored_nextpc", NextPC, 64'h504);
    drive(64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("seq_wrap", NextPC, 64'h0);
    drive(64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1'b0, 1'b0, 1'b1);
    chk("branch_wrap", NextPC, 64'h10);
    tick();
    chk("takenq_before_reset", {63'd0, TakenQ}, 64'd1);
    Reset = 1'b1;
    tick();
    chk("midstream_reset_takenq", {63'd0, TakenQ}, 64'd0);
    Reset = 1'b0;
`ifdef NEXTPC_STATS_EN
    drive(64'h0, 64'h8, 1'b1, 1'b0, 1'b0);
    tick();
    chk("cond_only_condcnt", {62'd0, CondCnt}, 64'd1);
    chk("cond_only_takencnt", {62'd0, TakenCnt}, 64'd0);
    chk("cond_only_uncondcnt", {62'd0, UncondCnt}, 64'd0);
    drive(64'h0, 64'h8, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_takencnt", {62'd0, TakenCnt}, 64'd3);
    chk("sat_uncondcnt", {62'd0, UncondCnt}, 64'd3);
    chk("sat_condcnt_held", {62'd0, CondCnt}, 64'd1);
    Reset = 1'b1;
    tick();
    chk("stats_reset_takencnt", {62'd0, TakenCnt}, 64'd0);
    chk("stats_reset_condcnt", {62'd0, CondCnt}, 64'd0);
    chk("stats_reset_uncondcnt", {62'd0, UncondCnt}, 64'd0);
    Reset = 1'b0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
